// File: rtl/im2col_pkg.sv
// ---------------------------------------------------------------------------
// im2col_pkg
// Shared definitions for the im2col streaming engine:
//   - state_t     : controller states (IDLE, RUN, DRAIN, DONE)
//   - COORD_W     : width of the signed source-coordinate arithmetic; covers
//                   image dimensions up to 2^(COORD_W-2)-1 with sign headroom
//   - NUM_LEVELS  : depth of the loop nest (oy, ox, c, ky, kx)
//   - out_dim()   : output extent along one axis for a given image/filter
//   - total_elems(): number of im2col elements written per pass
// ---------------------------------------------------------------------------
package im2col_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int COORD_W    = 16;
    localparam int NUM_LEVELS = 5;

    // (dim + 2*pad - k) / stride + 1, integer division
    function automatic int out_dim(input int img_dim, input int k,
                                   input int stride, input int pad);
        return (img_dim + 2 * pad - k) / stride + 1;
    endfunction

    function automatic int total_elems(input int img_c, input int img_w,
                                       input int img_h, input int k,
                                       input int stride, input int pad);
        return out_dim(img_h, k, stride, pad) * out_dim(img_w, k, stride, pad)
               * img_c * k * k;
    endfunction

endpackage

// File: rtl/im2col_stream_if.sv
// ---------------------------------------------------------------------------
// im2col_stream_if
// Scratch-memory port used by the im2col engine.
//   addr_rd   : read address (engine -> memory)
//   data_rd   : read data, valid one cycle after addr_rd (memory -> engine)
//   addr_wr   : write address (engine -> memory)
//   data_wr   : write data (engine -> memory)
//   mem_wr_en : write strobe (engine -> memory)
// Modports: master = engine side, slave = memory side.
// ---------------------------------------------------------------------------
interface im2col_stream_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr_rd;
    logic [DATA_WIDTH-1:0] data_rd;
    logic [ADDR_WIDTH-1:0] addr_wr;
    logic [DATA_WIDTH-1:0] data_wr;
    logic                  mem_wr_en;

    modport master (
        output addr_rd,
        output addr_wr,
        output data_wr,
        output mem_wr_en,
        input  data_rd
    );

    modport slave (
        input  addr_rd,
        input  addr_wr,
        input  data_wr,
        input  mem_wr_en,
        output data_rd
    );
endinterface

// File: rtl/im2col_addr_gen.sv
// ---------------------------------------------------------------------------
// im2col_addr_gen
// Five-level counter nest (oy, ox, c, ky, kx, kx innermost) with the source
// coordinate and address computation for the element currently pointed at.
// Ports:
//   clk     : clock
//   rst_n   : synchronous active-low reset, clears all counters
//   clear   : synchronous clear of all counters (start of a pass)
//   advance : step the nest by one element
//   last    : every counter is at its maximum (current element is the last)
//   addr    : source read address of the current element
//   pad     : current element lies in the zero border
// ---------------------------------------------------------------------------
module im2col_addr_gen
    import im2col_pkg::*;
#(
    parameter int                    IMG_C       = 1,
    parameter int                    IMG_W       = 8,
    parameter int                    IMG_H       = 8,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    FILTER_SIZE = 3,
    parameter int                    STRIDE      = 1,
    parameter int                    PAD         = 1,
    parameter logic [ADDR_WIDTH-1:0] IMG_BASE    = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  advance,
    output logic                  last,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  pad
);

    localparam int OUT_W = out_dim(IMG_W, FILTER_SIZE, STRIDE, PAD);
    localparam int OUT_H = out_dim(IMG_H, FILTER_SIZE, STRIDE, PAD);

    localparam logic [COORD_W-1:0]        STRIDE_C = COORD_W'(STRIDE);
    localparam logic [COORD_W-1:0]        PAD_C    = COORD_W'(PAD);
    localparam logic signed [COORD_W-1:0] IMG_W_S  = COORD_W'(IMG_W);
    localparam logic signed [COORD_W-1:0] IMG_H_S  = COORD_W'(IMG_H);
    localparam logic [ADDR_WIDTH-1:0]     PLANE_A  = ADDR_WIDTH'(IMG_H * IMG_W);
    localparam logic [ADDR_WIDTH-1:0]     IMG_W_A  = ADDR_WIDTH'(IMG_W);

    // Level index: 0 = kx, 1 = ky, 2 = c, 3 = ox, 4 = oy
    localparam int LVL_KX = 0;
    localparam int LVL_KY = 1;
    localparam int LVL_C  = 2;
    localparam int LVL_OX = 3;
    localparam int LVL_OY = 4;

    function automatic int level_max(input int lvl);
        case (lvl)
            LVL_KX, LVL_KY: return FILTER_SIZE - 1;
            LVL_C:          return IMG_C - 1;
            LVL_OX:         return OUT_W - 1;
            default:        return OUT_H - 1;
        endcase
    endfunction

    logic [NUM_LEVELS-1:0][COORD_W-1:0] cnt;
    logic [NUM_LEVELS-1:0]              at_max;
    logic [NUM_LEVELS-1:0]              carry;   // carry into each level

    assign carry[0] = advance;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEVELS; gi++) begin : g_level
            logic [COORD_W-1:0] cnt_reg;

            assign at_max[gi] = (cnt_reg == COORD_W'(level_max(gi)));
            assign cnt[gi]    = cnt_reg;

            if (gi < NUM_LEVELS - 1) begin : g_carry
                assign carry[gi+1] = carry[gi] & at_max[gi];
            end

            always_ff @(posedge clk) begin
                if (!rst_n || clear) begin
                    cnt_reg <= '0;
                end else if (carry[gi]) begin
                    cnt_reg <= at_max[gi] ? '0 : cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign last = &at_max;

    // Modular arithmetic in COORD_W bits, then read back as signed; the
    // result is the true signed coordinate as long as dimensions fit.
    logic signed [COORD_W-1:0] iy;
    logic signed [COORD_W-1:0] ix;
    logic        [COORD_W-1:0] iy_u;
    logic        [COORD_W-1:0] ix_u;

    assign iy   = $signed(cnt[LVL_OY] * STRIDE_C + cnt[LVL_KY] - PAD_C);
    assign ix   = $signed(cnt[LVL_OX] * STRIDE_C + cnt[LVL_KX] - PAD_C);
    assign iy_u = iy;
    assign ix_u = ix;

    assign pad = iy[COORD_W-1] || (iy >= IMG_H_S) ||
                 ix[COORD_W-1] || (ix >= IMG_W_S);

    // For padded elements this address is meaningless; the read result is
    // discarded downstream, so no gating is needed here.
    assign addr = IMG_BASE
                + ADDR_WIDTH'(cnt[LVL_C]) * PLANE_A
                + ADDR_WIDTH'(iy_u) * IMG_W_A
                + ADDR_WIDTH'(ix_u);

endmodule

// File: rtl/im2col_stream.sv
// ---------------------------------------------------------------------------
// im2col_stream
// Bufferless im2col engine: walks a CHW image in scratch memory and writes
// the im2col matrix back, one element per clock, padding synthesised in the
// address path.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset (aborts a pass immediately)
//   start     : launch pulse, accepted only in IDLE or DONE
//   mem       : scratch-memory port (im2col_stream_if.master)
//   busy      : high in RUN and DRAIN
//   done      : high in DONE
//   cycle_cnt : (IM2COL_PERF_CNT_EN only) cycles spent in RUN/DRAIN
//   pad_cnt   : (IM2COL_PERF_CNT_EN only) pad elements written
// Optional feature macro: IM2COL_PERF_CNT_EN
//
// Pipeline: in a RUN cycle the read address is driven straight from the
// address generator (stage 0) and the pad flag is registered; the next
// cycle writes data_rd (or zero for pad elements) at the next sequential
// output address (stage 1). DRAIN covers the write of the final element.
// ---------------------------------------------------------------------------
module im2col_stream
    import im2col_pkg::*;
#(
    parameter int                    IMG_C       = 1,
    parameter int                    IMG_W       = 8,
    parameter int                    IMG_H       = 8,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    FILTER_SIZE = 3,
    parameter int                    STRIDE      = 1,
    parameter int                    PAD         = 1,
    parameter logic [ADDR_WIDTH-1:0] IMG_BASE    = ADDR_WIDTH'(16'h0000),
    parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = ADDR_WIDTH'(16'h2000)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    im2col_stream_if.master         mem,
    output logic                    busy,
    output logic                    done
`ifdef IM2COL_PERF_CNT_EN
    ,
    output logic [31:0]             cycle_cnt,
    output logic [31:0]             pad_cnt
`endif
);

    // ---------------- FSM ----------------
    state_t state_reg;
    state_t state_next;
    logic   issue;       // stage 0 active: one element issued this cycle
    logic   start_ok;    // start accepted this cycle

    logic                  gen_last;
    logic [ADDR_WIDTH-1:0] gen_addr;
    logic                  gen_pad;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        start_ok   = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (gen_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg == RUN) || (state_reg == DRAIN);
    assign done = (state_reg == DONE);

    // ---------------- address generator ----------------
    im2col_addr_gen #(
        .IMG_C       (IMG_C),
        .IMG_W       (IMG_W),
        .IMG_H       (IMG_H),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .FILTER_SIZE (FILTER_SIZE),
        .STRIDE      (STRIDE),
        .PAD         (PAD),
        .IMG_BASE    (IMG_BASE)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_ok),
        .advance (issue),
        .last    (gen_last),
        .addr    (gen_addr),
        .pad     (gen_pad)
    );

    // ---------------- stage 0 ----------------
    logic [ADDR_WIDTH-1:0] addr_rd_reg;   // last issued read address
    logic                  pad_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_rd_reg <= IMG_BASE;
            pad_reg     <= 1'b0;
        end else if (issue) begin
            addr_rd_reg <= gen_addr;
            pad_reg     <= gen_pad;
        end
    end

    // Live address while issuing so the read lands one cycle ahead of the
    // write; otherwise hold the last issued address.
    assign mem.addr_rd = issue ? gen_addr : addr_rd_reg;

    // ---------------- stage 1 ----------------
    logic                  wr_en_reg;
    logic [ADDR_WIDTH-1:0] addr_wr_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en_reg   <= 1'b0;
            addr_wr_reg <= IM2COL_BASE;
        end else begin
            wr_en_reg <= issue;
            // Writes within a pass are back-to-back, so a stage-1 slot that
            // was idle marks the first element of a new pass.
            if (issue) begin
                addr_wr_reg <= wr_en_reg ? addr_wr_reg + 1'b1 : IM2COL_BASE;
            end
        end
    end

    assign mem.mem_wr_en = wr_en_reg;
    assign mem.addr_wr   = addr_wr_reg;
    assign mem.data_wr   = (wr_en_reg && !pad_reg) ? mem.data_rd : '0;

    // ---------------- optional performance counters ----------------
`ifdef IM2COL_PERF_CNT_EN
    logic [31:0] cycle_cnt_reg;
    logic [31:0] pad_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || start_ok) begin
            cycle_cnt_reg <= '0;
            pad_cnt_reg   <= '0;
        end else begin
            if (busy) begin
                cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            end
            if (wr_en_reg && pad_reg) begin
                pad_cnt_reg <= pad_cnt_reg + 32'd1;
            end
        end
    end

    assign cycle_cnt = cycle_cnt_reg;
    assign pad_cnt   = pad_cnt_reg;
`endif

endmodule

// File: tb/tb_im2col_stream.sv
// ---------------------------------------------------------------------------
// tb_im2col_stream
// Four engine instances with different geometries share clock and reset:
//   u0: defaults (1ch, 8x8, K3, S1, P1)
//   u1: STRIDE=2
//   u2: 5x5, PAD=0
//   u3: 2ch, 4x4, channel 1 holds 100+i
// Cycle numbers are counted as the index of the clock edge (relative to the
// edge that samples start) at which a signal is first sampled high.
// ---------------------------------------------------------------------------
module tb_im2col_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] start_v;

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // geometry tables (K = 3 everywhere)
    int cfg_c [4] = '{1, 1, 1, 2};
    int cfg_w [4] = '{8, 8, 5, 4};
    int cfg_h [4] = '{8, 8, 5, 4};
    int cfg_s [4] = '{1, 2, 1, 1};
    int cfg_p [4] = '{1, 1, 0, 1};
    int n_exp [4] = '{576, 144, 81, 288};

    im2col_stream_if #(.DATA_WIDTH(8), .ADDR_WIDTH(32)) m0 ();
    im2col_stream_if #(.DATA_WIDTH(8), .ADDR_WIDTH(32)) m1 ();
    im2col_stream_if #(.DATA_WIDTH(8), .ADDR_WIDTH(32)) m2 ();
    im2col_stream_if #(.DATA_WIDTH(8), .ADDR_WIDTH(32)) m3 ();

    logic [3:0]  busy_v;
    logic [3:0]  done_v;
    logic [3:0]  wr_en_v;
    logic [31:0] addr_wr_a [4];
    logic [31:0] addr_rd_a [4];
    logic [7:0]  data_wr_a [4];

`ifdef IM2COL_PERF_CNT_EN
    logic [31:0] cyc_cnt_a [4];
    logic [31:0] pad_cnt_a [4];
`endif

    // image contents: a+1, except channel 1 of the 2-channel image (100+i)
    function automatic logic [7:0] img_val(input int cfg, input logic [31:0] a);
        if (cfg == 3 && a >= 32'd16 && a < 32'd32) begin
            return 8'(a - 32'd16 + 32'd100);
        end
        return 8'(a + 32'd1);
    endfunction

    always @(posedge clk) m0.data_rd <= img_val(0, m0.addr_rd);
    always @(posedge clk) m1.data_rd <= img_val(1, m1.addr_rd);
    always @(posedge clk) m2.data_rd <= img_val(2, m2.addr_rd);
    always @(posedge clk) m3.data_rd <= img_val(3, m3.addr_rd);

    assign wr_en_v   = {m3.mem_wr_en, m2.mem_wr_en, m1.mem_wr_en, m0.mem_wr_en};
    assign addr_wr_a[0] = m0.addr_wr;
    assign addr_wr_a[1] = m1.addr_wr;
    assign addr_wr_a[2] = m2.addr_wr;
    assign addr_wr_a[3] = m3.addr_wr;
    assign addr_rd_a[0] = m0.addr_rd;
    assign addr_rd_a[1] = m1.addr_rd;
    assign addr_rd_a[2] = m2.addr_rd;
    assign addr_rd_a[3] = m3.addr_rd;
    assign data_wr_a[0] = m0.data_wr;
    assign data_wr_a[1] = m1.data_wr;
    assign data_wr_a[2] = m2.data_wr;
    assign data_wr_a[3] = m3.data_wr;

    im2col_stream u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mem(m0),
        .busy(busy_v[0]), .done(done_v[0])
`ifdef IM2COL_PERF_CNT_EN
        , .cycle_cnt(cyc_cnt_a[0]), .pad_cnt(pad_cnt_a[0])
`endif
    );

    im2col_stream #(.STRIDE(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mem(m1),
        .busy(busy_v[1]), .done(done_v[1])
`ifdef IM2COL_PERF_CNT_EN
        , .cycle_cnt(cyc_cnt_a[1]), .pad_cnt(pad_cnt_a[1])
`endif
    );

    im2col_stream #(.IMG_W(5), .IMG_H(5), .PAD(0)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mem(m2),
        .busy(busy_v[2]), .done(done_v[2])
`ifdef IM2COL_PERF_CNT_EN
        , .cycle_cnt(cyc_cnt_a[2]), .pad_cnt(pad_cnt_a[2])
`endif
    );

    im2col_stream #(.IMG_C(2), .IMG_W(4), .IMG_H(4)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .mem(m3),
        .busy(busy_v[3]), .done(done_v[3])
`ifdef IM2COL_PERF_CNT_EN
        , .cycle_cnt(cyc_cnt_a[3]), .pad_cnt(pad_cnt_a[3])
`endif
    );

    // ---------------- capture state ----------------
    logic [7:0] wr_data [1024];
    int nwr;
    int seq_err;
    int first_wr;
    int done_cyc;
    logic [31:0] last_wr_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Independent reference: decompose n by the loop nest order.
    function automatic logic [7:0] model_elem(input int cfg, input int n, output bit is_pad);
        int k, ow, kx, ky, c, pix, ox, oy, iy, ix;
        k   = 3;
        ow  = (cfg_w[cfg] + 2 * cfg_p[cfg] - k) / cfg_s[cfg] + 1;
        kx  = n % k;
        ky  = (n / k) % k;
        c   = (n / (k * k)) % cfg_c[cfg];
        pix = n / (k * k * cfg_c[cfg]);
        ox  = pix % ow;
        oy  = pix / ow;
        iy  = oy * cfg_s[cfg] + ky - cfg_p[cfg];
        ix  = ox * cfg_s[cfg] + kx - cfg_p[cfg];
        if (iy < 0 || iy >= cfg_h[cfg] || ix < 0 || ix >= cfg_w[cfg]) begin
            is_pad = 1'b1;
            return 8'd0;
        end
        is_pad = 1'b0;
        return img_val(cfg, 32'(c * cfg_h[cfg] * cfg_w[cfg] + iy * cfg_w[cfg] + ix));
    endfunction

    function automatic int model_mismatches(input int cfg, input int cnt, output int pads);
        int mm;
        bit p;
        logic [7:0] e;
        mm   = 0;
        pads = 0;
        for (int n = 0; n < cnt && n < 1024; n++) begin
            e = model_elem(cfg, n, p);
            if (p) pads++;
            if (wr_data[n] !== e) mm++;
        end
        return mm;
    endfunction

    // One pass on instance k. Optionally re-pulse start at sample j ==
    // extra_start_at, or pulse reset at sample j == abort_at and return.
    task automatic run_pass(input int k, input int extra_start_at, input int abort_at);
        nwr      = 0;
        seq_err  = 0;
        first_wr = -1;
        done_cyc = -1;
        start_v  = 4'(1 << k);
        @(posedge clk); #1;
        start_v  = 4'b0;
        for (int j = 0; j < 2000; j++) begin
            if (wr_en_v[k]) begin
                if (addr_wr_a[k] !== 32'h2000 + 32'(nwr)) seq_err++;
                if (nwr < 1024) wr_data[nwr] = data_wr_a[k];
                last_wr_addr = addr_wr_a[k];
                if (first_wr < 0) first_wr = j + 1;
                nwr++;
            end
            if (done_v[k]) begin
                done_cyc = j + 1;
                break;
            end
            if (j == abort_at) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            start_v = (j == extra_start_at) ? 4'(1 << k) : 4'b0;
            @(posedge clk); #1;
        end
        start_v = 4'b0;
    endtask

    task automatic check_pass(input string tag, input int k);
        int mm, pads;
        check({tag, "_count"}, 32'(nwr), 32'(n_exp[k]));
        check({tag, "_first_wr"}, 32'(first_wr), 32'd2);
        check({tag, "_done_cyc"}, 32'(done_cyc), 32'(n_exp[k] + 2));
        check({tag, "_seq"}, 32'(seq_err), 32'd0);
        mm = model_mismatches(k, nwr, pads);
        check({tag, "_model"}, 32'(mm), 32'd0);
        check({tag, "_busy_low"}, 32'(busy_v[k]), 32'd0);
`ifdef IM2COL_PERF_CNT_EN
        check({tag, "_cycle_cnt"}, cyc_cnt_a[k], 32'(n_exp[k] + 1));
        check({tag, "_pad_cnt"}, pad_cnt_a[k], 32'(pads));
`endif
    endtask

    logic [7:0] win_first [9] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd9, 8'd10};
    logic [7:0] win_last0 [9] = '{8'd55, 8'd56, 8'd0, 8'd63, 8'd64, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] win_s2    [9] = '{8'd0, 8'd0, 8'd0, 8'd2, 8'd3, 8'd4, 8'd10, 8'd11, 8'd12};
    logic [7:0] win_p0    [9] = '{8'd13, 8'd14, 8'd15, 8'd18, 8'd19, 8'd20, 8'd23, 8'd24, 8'd25};
    logic [7:0] win_ch1   [9] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd100, 8'd101, 8'd0, 8'd104, 8'd105};

    initial begin
        int zeros;
        int late_wr;
        rst_n   = 1'b0;
        start_v = 4'b0;
        repeat (3) @(posedge clk);
        #1;

        // ---- reset state ----
        check("rst_addr_rd", addr_rd_a[0], 32'h0000);
        check("rst_addr_wr", addr_wr_a[0], 32'h2000);
        check("rst_data_wr", 32'(data_wr_a[0]), 32'd0);
        check("rst_wr_en", 32'(wr_en_v), 32'd0);
        check("rst_busy", 32'(busy_v), 32'd0);
        check("rst_done", 32'(done_v), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- defaults ----
        run_pass(0, -1, -1);
        check_pass("def", 0);
        check("def_last_addr", last_wr_addr, 32'h223F);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("def_first_win[%0d]", i), 32'(wr_data[i]), 32'(win_first[i]));
            check($sformatf("def_last_win[%0d]", i), 32'(wr_data[567 + i]), 32'(win_last0[i]));
        end
        $display("pass def: writes=%0d first_wr=%0d done=%0d", nwr, first_wr, done_cyc);

        // ---- stride 2 ----
        run_pass(1, -1, -1);
        check_pass("s2", 1);
        for (int i = 0; i < 9; i++)
            check($sformatf("s2_win01[%0d]", i), 32'(wr_data[9 + i]), 32'(win_s2[i]));
        $display("pass s2: writes=%0d first_wr=%0d done=%0d", nwr, first_wr, done_cyc);

        // ---- pad 0, 5x5 ----
        run_pass(2, -1, -1);
        check_pass("p0", 2);
        zeros = 0;
        for (int n = 0; n < nwr && n < 1024; n++) if (wr_data[n] == 8'd0) zeros++;
        check("p0_zero_writes", 32'(zeros), 32'd0);
        for (int i = 0; i < 9; i++)
            check($sformatf("p0_last_win[%0d]", i), 32'(wr_data[72 + i]), 32'(win_p0[i]));
        $display("pass p0: writes=%0d first_wr=%0d done=%0d", nwr, first_wr, done_cyc);

        // ---- two channels ----
        run_pass(3, -1, -1);
        check_pass("c2", 3);
        for (int i = 0; i < 9; i++)
            check($sformatf("c2_ch1_win[%0d]", i), 32'(wr_data[9 + i]), 32'(win_ch1[i]));
        check("c2_elem13", 32'(wr_data[13]), 32'd100);
        $display("pass c2: writes=%0d first_wr=%0d done=%0d", nwr, first_wr, done_cyc);

        // ---- start pulsed mid-run (from DONE) ----
        run_pass(0, 100, -1);
        check_pass("midstart", 0);
        $display("pass midstart: writes=%0d done=%0d", nwr, done_cyc);

        // ---- reset mid-run ----
        run_pass(0, -1, 50);
        check("abort_wr_en", 32'(wr_en_v[0]), 32'd0);
        check("abort_busy", 32'(busy_v[0]), 32'd0);
        late_wr = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (wr_en_v[0]) late_wr++;
        end
        check("abort_no_writes", 32'(late_wr), 32'd0);
        $display("abort: writes_before=%0d writes_after=%0d", nwr, late_wr);

        run_pass(0, -1, -1);
        check_pass("after_abort", 0);
        for (int i = 0; i < 9; i++)
            check($sformatf("after_abort_win[%0d]", i), 32'(wr_data[i]), 32'(win_first[i]));
        $display("pass after_abort: writes=%0d done=%0d", nwr, done_cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
